// File: rtl/uart_tx_pkg.sv
// Shared constants for the sequencer-driven UART transmitter: opcodes, FSM encoding, status bits.
// The Parity state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam logic [3:0] OpNop    = 4'h0;
  localparam logic [3:0] OpSend   = 4'h1;
  localparam logic [3:0] OpClrErr = 4'h2;

  localparam int unsigned StatusReadyBit = 0;
  localparam int unsigned StatusErrorBit = 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period divider: counts clock cycles within one serial bit, restarted by clear_i.
// tick_o is high on the last cycle of each bit period.
module uart_tx_baud #(
  parameter int unsigned BaudDiv = 434
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 16'(BaudDiv - 1));

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter controlled by 12-bit sequencer instructions (8N1, or 8E1 with UART_TX_PARITY_EN).
// status_o = {6'b0, error, ready}.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BaudDiv = 434
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [11:0] inst_i,
  input  logic        inst_en_i,
  output logic        tx_o,
  output logic [7:0]  status_o
);

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        err_q, err_d;
  logic        tx_q, tx_d;
  logic        tick, baud_clr;
  logic [3:0]  opcode;
  logic [7:0]  imm;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  assign opcode = inst_i[11:8];
  assign imm    = inst_i[7:0];

  uart_tx_baud #(.BaudDiv(BaudDiv)) u_baud (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (baud_clr),
    .tick_o  (tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      StIdle: begin
        if (inst_en_i && opcode == OpSend) begin
          shreg_d = imm;
`ifdef UART_TX_PARITY_EN
          par_d   = ^imm;
`endif
          state_d = StStart;
        end
      end
      StStart: if (tick) state_d = StData;
      StData: begin
        if (tick) begin
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: if (tick) state_d = StStop;
`endif
      StStop: if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Register tx from the next state so the line changes together with the state
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase

    baud_clr = (state_q == StIdle) || (state_d != state_q);

    err_d = err_q;
    if (inst_en_i) begin
      case (opcode)
        OpNop:    err_d = err_q;
        OpSend:   if (state_q != StIdle) err_d = 1'b1;
        OpClrErr: err_d = 1'b0;
        default:  err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      err_q    <= 1'b0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      err_q    <= err_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx_o = tx_q;

  always_comb begin
    status_o                 = 8'h00;
    status_o[StatusReadyBit] = (state_q == StIdle);
    status_o[StatusErrorBit] = err_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with BaudDiv=4; honours UART_TX_PARITY_EN for frame format.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FL = NSLOT * BD;

  logic        clock, reset, inst_en, tx;
  logic [11:0] inst;
  logic [7:0]  status;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [3:0] op;
    logic [7:0] imm;
    logic [7:0] exp_st;
  } vec_t;

  vec_t vecs[8];

  uart_tx #(.BaudDiv(BD)) dut (
    .clock_i   (clock),
    .reset_i   (reset),
    .inst_i    (inst),
    .inst_en_i (inst_en),
    .tx_o      (tx),
    .status_o  (status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected line level for every cycle of a frame, one bit per cycle
  function automatic logic [63:0] exp_frame(input logic [7:0] b);
    logic [63:0] f;
    int slot;
    f = '0;
    for (int i = 0; i < FL; i++) begin
      slot = i / BD;
      if (slot == 0)                      f[i] = 1'b0;
      else if (slot <= 8)                 f[i] = b[slot-1];
      else if (slot == 9 && NSLOT == 11)  f[i] = ^b;
      else                                f[i] = 1'b1;
    end
    return f;
  endfunction

  task automatic drive(input logic en, input logic [3:0] op, input logic [7:0] imm);
    inst_en = en;
    inst    = {op, imm};
  endtask

  // Called on the negedge where SEND was driven; returns on the frame's last cycle
  task automatic run_frame(input int inj_k, input logic [3:0] inj_op, input logic [7:0] inj_imm,
                           output logic [63:0] got, output logic [7:0] st_last,
                           output logic ready_seen);
    got = '0;
    ready_seen = 1'b0;
    st_last = '0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clock);
      drive(1'b0, OpNop, 8'h00);
      if (k == inj_k) drive(1'b1, inj_op, inj_imm);
      got[k] = tx;
      if (status[0]) ready_seen = 1'b1;
      st_last = status;
    end
  endtask

  logic [63:0] got;
  logic [7:0]  st;
  logic        rs;

  initial begin
    logic        cur_tx, cur_ready, cur_err, en;
    logic [3:0]  op;
    logic [7:0]  imm;
    logic [63:0] f;
    int          r;
    logic        q[$];

    vecs[0] = '{1'b0, OpSend,   8'h12, 8'h01};
    vecs[1] = '{1'b1, OpNop,    8'h00, 8'h01};
    vecs[2] = '{1'b1, 4'h7,     8'h00, 8'h03};
    vecs[3] = '{1'b1, OpNop,    8'h55, 8'h03};
    vecs[4] = '{1'b1, OpClrErr, 8'h00, 8'h01};
    vecs[5] = '{1'b1, 4'hF,     8'hAA, 8'h03};
    vecs[6] = '{1'b0, OpClrErr, 8'h00, 8'h03};
    vecs[7] = '{1'b1, OpClrErr, 8'h00, 8'h01};

    reset = 1'b1;
    drive(1'b0, OpNop, 8'h00);
    repeat (3) @(negedge clock);
    check("reset_tx", tx, 1'b1);
    check("reset_status", status, 8'h01);

    // First SEND presented on the first edge after reset release
    reset = 1'b0;
    drive(1'b1, OpSend, 8'hA5);
    run_frame(-1, OpNop, 8'h00, got, st, rs);
    check("frame_a5", got, exp_frame(8'hA5));
    check("busy_a5", rs, 1'b0);
    @(negedge clock);
    check("ready_after_a5", status, 8'h01);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].en, vecs[i].op, vecs[i].imm);
      @(negedge clock);
      drive(1'b0, OpNop, 8'h00);
      check($sformatf("vec%0d", i), {tx, status}, {1'b1, vecs[i].exp_st});
    end

    // Back-to-back frames
    drive(1'b1, OpSend, 8'h3C);
    run_frame(-1, OpNop, 8'h00, got, st, rs);
    check("frame_3c", got, exp_frame(8'h3C));
    @(negedge clock);
    check("ready_between", status, 8'h01);
    drive(1'b1, OpSend, 8'h55);
    run_frame(-1, OpNop, 8'h00, got, st, rs);
    check("frame_55", got, exp_frame(8'h55));
    check("busy_55", rs, 1'b0);
    @(negedge clock);
    check("status_after_b2b", status, 8'h01);

    // SEND while busy is dropped and flags error
    drive(1'b1, OpSend, 8'h01);
    run_frame(4, OpSend, 8'hFF, got, st, rs);
    check("frame_01", got, exp_frame(8'h01));
    check("status_in_frame_01", st, 8'h02);
    @(negedge clock);
    check("status_after_01", status, 8'h03);
    drive(1'b1, OpClrErr, 8'h00);
    @(negedge clock);
    drive(1'b0, OpNop, 8'h00);
    check("clrerr_idle", status, 8'h01);

    // Undefined opcode sets error; CLRERR mid-frame clears it
    drive(1'b1, 4'h7, 8'h00);
    @(negedge clock);
    drive(1'b0, OpNop, 8'h00);
    check("undef_op", status, 8'h03);
    drive(1'b1, OpSend, 8'hC3);
    run_frame(10, OpClrErr, 8'h00, got, st, rs);
    check("frame_c3", got, exp_frame(8'hC3));
    check("clrerr_busy", st, 8'h00);
    @(negedge clock);
    check("status_after_c3", status, 8'h01);

    // Async reset during data bit 3
    drive(1'b1, OpSend, 8'hF0);
    for (int k = 0; k < 18; k++) begin
      @(negedge clock);
      drive(1'b0, OpNop, 8'h00);
      if (k == 2) drive(1'b1, 4'h9, 8'h00);
    end
    check("bit3_before_reset", {tx, status}, {1'b0, 8'h02});
    #1 reset = 1'b1;
    #1;
    check("async_reset", {tx, status}, {1'b1, 8'h01});
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, OpSend, 8'h96);
    run_frame(-1, OpNop, 8'h00, got, st, rs);
    check("frame_after_reset", got, exp_frame(8'h96));
    @(negedge clock);
    check("ready_after_reset_frame", status, 8'h01);

`ifdef UART_TX_PARITY_EN
    drive(1'b1, OpSend, 8'h07);
    run_frame(-1, OpNop, 8'h00, got, st, rs);
    check("frame_07", got, exp_frame(8'h07));
    check("parity_07", got[9*BD], 1'b1);
    @(negedge clock);
    check("len_07", status, 8'h01);
    drive(1'b1, OpSend, 8'h03);
    run_frame(-1, OpNop, 8'h00, got, st, rs);
    check("parity_03", got[9*BD], 1'b0);
    @(negedge clock);
    check("len_03", status, 8'h01);
`endif

    // Random instruction stream against a cycle-level line model
    cur_tx = 1'b1;
    cur_ready = 1'b1;
    cur_err = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      check("rand", {tx, status}, {cur_tx, 6'b0, cur_err, cur_ready});
      en = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      if (r < 5)      op = OpSend;
      else if (r < 7) op = OpClrErr;
      else if (r < 8) op = OpNop;
      else            op = 4'($urandom_range(3, 15));
      imm = 8'($urandom);
      drive(en, op, imm);
      if (en) begin
        if (op == OpSend) begin
          if (cur_ready) begin
            f = exp_frame(imm);
            for (int i = 0; i < FL; i++) q.push_back(f[i]);
          end else begin
            cur_err = 1'b1;
          end
        end else if (op == OpClrErr) begin
          cur_err = 1'b0;
        end else if (op != OpNop) begin
          cur_err = 1'b1;
        end
      end
      if (q.size() > 0) begin
        cur_tx = q.pop_front();
        cur_ready = 1'b0;
      end else begin
        cur_tx = 1'b1;
        cur_ready = 1'b1;
      end
      @(negedge clock);
    end
    drive(1'b0, OpNop, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
